// File: rtl/estagio_busca_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
interface estagio_busca_if;
    logic [31:0] endereco;
    logic [31:0] instrucao;

    modport master (output endereco, input instrucao);
    modport slave  (input endereco, output instrucao);
endinterface

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/flush/redirect handling.
// Optional macro FETCH_STATS_EN adds the n_buscas fetched-instruction counter output.
module estagio_busca #(
    parameter int unsigned PROG_WORDS = 13,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  desvio,
    input  logic [31:0]           alvo_desvio,
    estagio_busca_if.master       imem,
    output logic [31:0]           if_id_instrucao,
    output logic [31:0]           if_id_pc4,
    output logic                  if_id_valido,
`ifdef FETCH_STATS_EN
    output logic [31:0]           n_buscas,
`endif
    output logic                  parado
);

    localparam logic [31:0] LIMITE = 32'(PROG_WORDS * 4);

    typedef enum logic {BUSCA, FIM} estado_t;

    estado_t     r_estado;
    logic [31:0] r_pc;
    logic [31:0] r_instrucao;
    logic [31:0] r_pc4;
    logic        r_valido;
    logic        r_parado;
    logic [31:0] w_pc4;
    logic [31:0] w_alvo;

    assign w_pc4  = r_pc + 32'd4;
    assign w_alvo = {alvo_desvio[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= BUSCA;
            r_pc        <= RESET_PC;
            r_instrucao <= '0;
            r_pc4       <= '0;
            r_valido    <= 1'b0;
            r_parado    <= 1'b0;
        end else if (desvio) begin
            r_pc        <= w_alvo;
            r_instrucao <= '0;
            r_pc4       <= '0;
            r_valido    <= 1'b0;
            r_estado    <= (w_alvo < LIMITE) ? BUSCA : FIM;
            r_parado    <= !(w_alvo < LIMITE);
        end else if (stall) begin
            if (flush) begin
                r_instrucao <= '0;
                r_pc4       <= '0;
                r_valido    <= 1'b0;
            end
        end else if (r_estado == BUSCA) begin
            r_pc <= w_pc4;
            if (flush) begin
                r_instrucao <= '0;
                r_pc4       <= '0;
                r_valido    <= 1'b0;
            end else begin
                r_instrucao <= imem.instrucao;
                r_pc4       <= w_pc4;
                r_valido    <= 1'b1;
            end
            if (w_pc4 >= LIMITE) begin
                r_estado <= FIM;
                r_parado <= 1'b1;
            end
        end else begin
            r_instrucao <= '0;
            r_pc4       <= '0;
            r_valido    <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_n_buscas;

    // Counts exactly the edges on which the BUSCA branch above loads a real instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_n_buscas <= '0;
        else if (!desvio && !stall && !flush && r_estado == BUSCA)
            r_n_buscas <= r_n_buscas + 32'd1;
    end

    assign n_buscas = r_n_buscas;
`endif

    assign imem.endereco   = r_pc;
    assign if_id_instrucao = r_instrucao;
    assign if_id_pc4       = r_pc4;
    assign if_id_valido    = r_valido;
    assign parado          = r_parado;

endmodule

// File: tb/tb_estagio_busca.sv
// Directed, table-driven bench for estagio_busca (PROG_WORDS=13, RESET_PC=0).
module tb_estagio_busca;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        desvio;
    logic [31:0] alvo_desvio;
    logic [31:0] if_id_instrucao;
    logic [31:0] if_id_pc4;
    logic        if_id_valido;
    logic        parado;
`ifdef FETCH_STATS_EN
    logic [31:0] n_buscas;
`endif

    estagio_busca_if bus ();

    estagio_busca #(.PROG_WORDS(13), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .desvio          (desvio),
        .alvo_desvio     (alvo_desvio),
        .imem            (bus),
        .if_id_instrucao (if_id_instrucao),
        .if_id_pc4       (if_id_pc4),
        .if_id_valido    (if_id_valido),
`ifdef FETCH_STATS_EN
        .n_buscas        (n_buscas),
`endif
        .parado          (parado)
    );

    // Memory model: word k holds C0DE_0000 + k.
    assign bus.instrucao = 32'hC0DE_0000 + {2'b00, bus.endereco[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        dv;
        logic [31:0] alvo;
        logic [31:0] e_end;
        logic [31:0] e_ins;
        logic [31:0] e_pc4;
        logic        e_val;
        logic        e_par;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    function automatic logic [31:0] wd(int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic add(input logic st, input logic fl, input logic dv, input logic [31:0] alvo,
                       input logic [31:0] e_end, input logic [31:0] e_ins, input logic [31:0] e_pc4,
                       input logic e_val, input logic e_par);
        vec_t v;
        v.st = st; v.fl = fl; v.dv = dv; v.alvo = alvo;
        v.e_end = e_end; v.e_ins = e_ins; v.e_pc4 = e_pc4; v.e_val = e_val; v.e_par = e_par;
        vecs.push_back(v);
    endtask

    // Plain fetch edge expecting word k in IF/ID.
    task automatic add_word(input logic [31:0] e_end, input int k, input logic e_par);
        add(0, 0, 0, 0, e_end, wd(k), 32'(4 * (k + 1)), 1, e_par);
    endtask

    task automatic check(input string name, input logic [31:0] e_end, input logic [31:0] e_ins,
                         input logic [31:0] e_pc4, input logic e_val, input logic e_par);
        n_tests++;
        if (bus.endereco !== e_end || if_id_instrucao !== e_ins || if_id_pc4 !== e_pc4 ||
            if_id_valido !== e_val || parado !== e_par) begin
            n_fail++;
            $display("FAIL %s: got end=%h ins=%h pc4=%h val=%b par=%b, want end=%h ins=%h pc4=%h val=%b par=%b",
                     name, bus.endereco, if_id_instrucao, if_id_pc4, if_id_valido, parado,
                     e_end, e_ins, e_pc4, e_val, e_par);
        end
    endtask

    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; desvio = 1'b0; alvo_desvio = '0;

        // Free run from reset: edge k loads word k-1, endereco = 4k.
        for (int k = 1; k <= 13; k++) add_word(32'(4 * k), k - 1, k == 13);
        add(0, 0, 0, 0, 52, 0, 0, 0, 1);
        add(0, 0, 0, 0, 52, 0, 0, 0, 1);
        // Redirect out of FIM, then to beyond LIMITE.
        add(0, 0, 1, 16, 16, 0, 0, 0, 0);
        add_word(20, 4, 0);
        add(0, 0, 1, 60, 60, 0, 0, 0, 1);
        add(0, 0, 0, 0, 60, 0, 0, 0, 1);
        // Stall three cycles at endereco=8.
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_word(4, 0, 0);
        add_word(8, 1, 0);
        add(1, 0, 0, 0, 8, wd(1), 8, 1, 0);
        add(1, 0, 0, 0, 8, wd(1), 8, 1, 0);
        add(1, 0, 0, 0, 8, wd(1), 8, 1, 0);
        add_word(12, 2, 0);
        // Unaligned desvio overriding stall at endereco=12.
        add(1, 0, 1, 32'h15, 20, 0, 0, 0, 0);
        add_word(24, 5, 0);
        // Flush without stall at endereco=4.
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_word(4, 0, 0);
        add(0, 1, 0, 0, 8, 0, 0, 0, 0);
        // Flush with stall at endereco=4.
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add_word(4, 0, 0);
        add(1, 1, 0, 0, 4, 0, 0, 0, 0);
        add_word(8, 1, 0);
        // Branch to the last word: it enters IF/ID as parado rises.
        add(0, 0, 1, 48, 48, 0, 0, 0, 0);
        add_word(52, 12, 1);

        #12;
        check("reset_state", 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            stall = vecs[i].st; flush = vecs[i].fl; desvio = vecs[i].dv; alvo_desvio = vecs[i].alvo;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_end, vecs[i].e_ins, vecs[i].e_pc4,
                  vecs[i].e_val, vecs[i].e_par);
            stall = 1'b0; flush = 1'b0; desvio = 1'b0; alvo_desvio = '0;
        end

        // Asynchronous reset mid-cycle at endereco=28.
        desvio = 1'b1; alvo_desvio = 28;
        @(posedge clk);
        #1 desvio = 1'b0; alvo_desvio = '0;
        add_word(32, 0, 0);  // keeps helper shape; not applied
        void'(vecs.pop_back());
        check("goto_28", 28, 0, 0, 0, 0);
        @(posedge clk);
        #1 check("fetch_at_28", 32, wd(7), 32, 1, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, 0, 0, 0, 0);
`ifdef FETCH_STATS_EN
        n_tests++;
        if (n_buscas !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d want 0", n_buscas);
        end
`endif
        @(posedge clk);
        #1 check("reset_held", 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;

        // Full run from reset with a bounded wait for parado.
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (parado) break;
        end
        n_tests++;
        if (!parado || cyc != 13) begin
            n_fail++;
            $display("FAIL run_to_fim: parado=%b after %0d edges, want 1 after 13", parado, cyc);
        end
        check("last_word", 52, wd(12), 52, 1, 1);
`ifdef FETCH_STATS_EN
        n_tests++;
        if (n_buscas !== 32'd13) begin
            n_fail++;
            $display("FAIL stats_count: got %0d want 13", n_buscas);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
